// File: rtl/multipit_pkg.sv
// Shared types and defaults for the multi-channel programmable interval timer.
package multipit_pkg;

   localparam int DEF_NUM_CH  = 4;
   localparam int DEF_COUNT_W = 16;
   localparam int DEF_PRESC_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } chState_e;

   // Channel-select width; a single channel still needs a one-bit select.
   function automatic int selWidth(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/multipit_if.sv
// Configuration, readback and interrupt signals of the timer, grouped for port use.
interface multipit_if
   import multipit_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int COUNT_W = DEF_COUNT_W,
   parameter int PRESC_W = DEF_PRESC_W
) ();

   localparam int CH_W = selWidth(NUM_CH);

   logic                cfg_we;
   logic [CH_W-1:0]     cfg_ch;
   logic [COUNT_W-1:0]  cfg_reload;
   logic                cfg_enable;
   logic                cfg_repeating;
   logic                cfg_divider_on;
   logic [PRESC_W-1:0]  presc_div;
   logic [NUM_CH-1:0]   irq_clear;
   logic [CH_W-1:0]     rd_ch;
   logic [COUNT_W-1:0]  rd_count;
   logic [NUM_CH-1:0]   irq_pulse;
   logic [NUM_CH-1:0]   irq_pending;
   logic                irq_any;

   modport master (
      output cfg_we, cfg_ch, cfg_reload, cfg_enable, cfg_repeating, cfg_divider_on,
             presc_div, irq_clear, rd_ch,
      input  rd_count, irq_pulse, irq_pending, irq_any
   );

   modport slave (
      input  cfg_we, cfg_ch, cfg_reload, cfg_enable, cfg_repeating, cfg_divider_on,
             presc_div, irq_clear, rd_ch,
      output rd_count, irq_pulse, irq_pending, irq_any
   );

endinterface

// File: rtl/multipit_channel.sv
// One timer channel: down-counter with reload, IDLE/RUN/DONE state, expiry pulse and sticky pending flag.
module multipit_channel
   import multipit_pkg::*;
#(
   parameter int COUNT_W = DEF_COUNT_W
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               wr_i,
   input  logic [COUNT_W-1:0] reload_i,
   input  logic               enable_i,
   input  logic               repeating_i,
   input  logic               divider_on_i,
   input  logic               tick_i,
   input  logic               clear_i,
   output logic [COUNT_W-1:0] count_o,
   output logic               pulse_o,
   output logic               pending_o
);

   chState_e           state_q, state_d;
   logic [COUNT_W-1:0] count_q, count_d;
   logic [COUNT_W-1:0] reload_q, reload_d;
   logic               repeat_q, repeat_d;
   logic               divOn_q, divOn_d;
   logic               pulse_q, pulse_d;
   logic               pending_q, pending_d;
   logic               step;
   logic               expire;

   assign step = divOn_q ? tick_i : 1'b1;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= IDLE;
         count_q   <= '0;
         reload_q  <= '0;
         repeat_q  <= 1'b0;
         divOn_q   <= 1'b0;
         pulse_q   <= 1'b0;
         pending_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         count_q   <= count_d;
         reload_q  <= reload_d;
         repeat_q  <= repeat_d;
         divOn_q   <= divOn_d;
         pulse_q   <= pulse_d;
         pending_q <= pending_d;
      end
   end

   // A write always takes priority, so an expiry coinciding with it is dropped.
   always_comb begin
      state_d  = state_q;
      count_d  = count_q;
      reload_d = reload_q;
      repeat_d = repeat_q;
      divOn_d  = divOn_q;
      expire   = 1'b0;
      if (wr_i) begin
         if (enable_i && (reload_i != '0)) begin
            state_d  = RUN;
            count_d  = reload_i;
            reload_d = reload_i;
            repeat_d = repeating_i;
            divOn_d  = divider_on_i;
         end else begin
            state_d = IDLE;
            count_d = '0;
         end
      end else if ((state_q == RUN) && step) begin
         if (count_q == COUNT_W'(1)) begin
            expire = 1'b1;
            if (repeat_q) begin
               count_d = reload_q;
            end else begin
               state_d = DONE;
               count_d = '0;
            end
         end else begin
            count_d = count_q - COUNT_W'(1);
         end
      end
   end

   // Setting the pending flag outranks a simultaneous clear.
   always_comb begin
      pulse_d   = expire;
      pending_d = expire | (pending_q & ~clear_i);
   end

   assign count_o   = count_q;
   assign pulse_o   = pulse_q;
   assign pending_o = pending_q;

endmodule

// File: rtl/multipit.sv
// Multi-channel interval timer top: shared prescaler, NUM_CH channel instances and the readback mux.
module multipit
   import multipit_pkg::*;
#(
   parameter int NUM_CH  = DEF_NUM_CH,
   parameter int COUNT_W = DEF_COUNT_W,
   parameter int PRESC_W = DEF_PRESC_W
) (
   input  logic      clk,
   input  logic      reset,
   multipit_if.slave bus
);

   localparam int CH_W = selWidth(NUM_CH);
   localparam int CH_N = 1 << CH_W;

   logic [PRESC_W-1:0] presc_q, presc_d;
   logic               tick;
   logic [COUNT_W-1:0] countTab [CH_N];
   logic [NUM_CH-1:0]  wrSel;
   logic [NUM_CH-1:0]  pulseVec;
   logic [NUM_CH-1:0]  pendVec;

   assign tick    = (presc_q == bus.presc_div);
   assign presc_d = tick ? '0 : presc_q + PRESC_W'(1);

   always_ff @(posedge clk) begin
      if (reset) begin
         presc_q <= '0;
      end else begin
         presc_q <= presc_d;
      end
   end

   // The readback table is padded to a power of two so unused selects read as zero.
   for (genvar i = 0; i < CH_N; i++) begin : gCh
      if (i < NUM_CH) begin : gReal
         assign wrSel[i] = bus.cfg_we && (bus.cfg_ch == CH_W'(i));
         multipit_channel #(.COUNT_W(COUNT_W)) uCh (
            .clk          (clk),
            .reset        (reset),
            .wr_i         (wrSel[i]),
            .reload_i     (bus.cfg_reload),
            .enable_i     (bus.cfg_enable),
            .repeating_i  (bus.cfg_repeating),
            .divider_on_i (bus.cfg_divider_on),
            .tick_i       (tick),
            .clear_i      (bus.irq_clear[i]),
            .count_o      (countTab[i]),
            .pulse_o      (pulseVec[i]),
            .pending_o    (pendVec[i])
         );
      end else begin : gPad
         assign countTab[i] = '0;
      end
   end

   assign bus.rd_count    = countTab[bus.rd_ch];
   assign bus.irq_pulse   = pulseVec;
   assign bus.irq_pending = pendVec;
   assign bus.irq_any     = |pendVec;

endmodule

// File: tb/tb_multipit.sv
// Self-checking bench for multipit: directed scenarios plus random traffic against an arithmetic timing model.
module tb_multipit;

   localparam int NUM_CH  = 4;
   localparam int COUNT_W = 16;
   localparam int PRESC_W = 8;
   localparam int CH_W    = 2;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   multipit_if #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .PRESC_W(PRESC_W)) bus ();

   multipit #(.NUM_CH(NUM_CH), .COUNT_W(COUNT_W), .PRESC_W(PRESC_W)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: each running channel is described by its write edge and mode; the
   // count and expiry edges follow from elapsed steps since that write.
   int edgeIdx;
   int presc;
   bit mActive [NUM_CH];
   int mW      [NUM_CH];
   int mN      [NUM_CH];
   bit mRep    [NUM_CH];
   bit mDiv    [NUM_CH];
   bit mPend   [NUM_CH];
   bit mPulse  [NUM_CH];

   function automatic int stepsDone(input int ch, input int e);
      if (mDiv[ch]) return (e / presc) - (mW[ch] / presc);
      return e - mW[ch];
   endfunction

   function automatic int expCount(input int ch);
      int s;
      if (!mActive[ch]) return 0;
      s = stepsDone(ch, edgeIdx);
      if (mRep[ch]) return mN[ch] - (s % mN[ch]);
      return (s >= mN[ch]) ? 0 : mN[ch] - s;
   endfunction

   task automatic modelEdge();
      int  s;
      bit  stepEdge;
      if (reset) begin
         edgeIdx = 0;
         for (int c = 0; c < NUM_CH; c++) begin
            mActive[c] = 0; mPend[c] = 0; mPulse[c] = 0;
            mRep[c] = 0; mDiv[c] = 0; mN[c] = 0; mW[c] = 0;
         end
         return;
      end
      edgeIdx++;
      presc = int'(bus.presc_div) + 1;
      for (int c = 0; c < NUM_CH; c++) begin
         mPulse[c] = 0;
         if (bus.cfg_we && (int'(bus.cfg_ch) == c)) begin
            if (bus.cfg_enable && (bus.cfg_reload != '0)) begin
               mActive[c] = 1;
               mW[c]      = edgeIdx;
               mN[c]      = int'(bus.cfg_reload);
               mRep[c]    = bus.cfg_repeating;
               mDiv[c]    = bus.cfg_divider_on;
            end else begin
               mActive[c] = 0;
            end
         end else if (mActive[c]) begin
            s        = stepsDone(c, edgeIdx);
            stepEdge = !mDiv[c] || ((edgeIdx % presc) == 0);
            if (stepEdge && (s > 0) && ((s % mN[c]) == 0) && (mRep[c] || (s == mN[c])))
               mPulse[c] = 1;
         end
         mPend[c] = mPulse[c] | (mPend[c] & !bus.irq_clear[c]);
      end
   endtask

   task automatic checkEq(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected) else begin
         failures++;
         $error("[TB] FAIL %s t=%0t observed=%0h expected=%0h", tag, $time, observed, expected);
      end
   endtask

   task automatic checkOutput();
      logic [NUM_CH-1:0] expPulse;
      logic [NUM_CH-1:0] expPend;
      for (int c = 0; c < NUM_CH; c++) begin
         expPulse[c] = mPulse[c];
         expPend[c]  = mPend[c];
      end
      checkEq("irq_pulse", 32'(bus.irq_pulse), 32'(expPulse));
      checkEq("irq_pending", 32'(bus.irq_pending), 32'(expPend));
      checkEq("irq_any", 32'(bus.irq_any), 32'(|expPend));
      checkEq($sformatf("rd_count ch%0d", bus.rd_ch), 32'(bus.rd_count), 32'(expCount(int'(bus.rd_ch))));
   endtask

   // One clock: DUT and model consume the same inputs, strobes drop, outputs checked on the falling edge.
   task automatic stepCycle();
      @(posedge clk);
      modelEdge();
      #1;
      bus.cfg_we    = 1'b0;
      bus.irq_clear = '0;
      bus.rd_ch     = CH_W'($urandom_range(0, NUM_CH - 1));
      @(negedge clk);
      checkOutput();
   endtask

   task automatic applyStimulus(input int ch, input int reload, input bit en, input bit rep, input bit div);
      bus.cfg_we         = 1'b1;
      bus.cfg_ch         = CH_W'(ch);
      bus.cfg_reload     = COUNT_W'(reload);
      bus.cfg_enable     = en;
      bus.cfg_repeating  = rep;
      bus.cfg_divider_on = div;
      stepCycle();
   endtask

   task automatic waitPulse(input int ch, input int maxEdges, output int edges);
      edges = -1;
      for (int i = 1; i <= maxEdges; i++) begin
         stepCycle();
         if (bus.irq_pulse[ch] === 1'b1) begin
            edges = i;
            break;
         end
      end
   endtask

   initial begin
      int e;
      int seen;

      bus.cfg_we = 1'b0; bus.cfg_ch = '0; bus.cfg_reload = '0;
      bus.cfg_enable = 1'b0; bus.cfg_repeating = 1'b0; bus.cfg_divider_on = 1'b0;
      bus.presc_div = PRESC_W'(4); bus.irq_clear = '0; bus.rd_ch = '0;

      reset = 1'b1;
      stepCycle();
      stepCycle();
      checkEq("reset irq_pulse", 32'(bus.irq_pulse), 32'h0);
      checkEq("reset irq_pending", 32'(bus.irq_pending), 32'h0);
      checkEq("reset irq_any", 32'(bus.irq_any), 32'h0);
      reset = 1'b0;

      // Repeating, divider off, reload 10.
      applyStimulus(0, 10, 1, 1, 0);
      waitPulse(0, 15, e); checkEq("ch0 first pulse", e, 10);
      waitPulse(0, 15, e); checkEq("ch0 second pulse", e, 10);
      waitPulse(0, 15, e); checkEq("ch0 third pulse", e, 10);
      checkEq("ch0 pending", 32'(bus.irq_pending[0]), 1);
      checkEq("ch0 irq_any", 32'(bus.irq_any), 1);

      // Clear coinciding with the fourth expiry, then a lone clear.
      for (int i = 0; i < 9; i++) stepCycle();
      bus.irq_clear = 4'b0001;
      stepCycle();
      checkEq("clear+expiry pulse", 32'(bus.irq_pulse[0]), 1);
      checkEq("clear+expiry pending", 32'(bus.irq_pending[0]), 1);
      bus.irq_clear = 4'b0001;
      stepCycle();
      checkEq("lone clear pending", 32'(bus.irq_pending[0]), 0);
      applyStimulus(0, 0, 0, 0, 0);

      // One-shot through the prescaler, write aligned to a prescaler wrap.
      for (int i = 0; i < 5 && ((edgeIdx + 1) % 5) != 0; i++) stepCycle();
      applyStimulus(1, 3, 1, 0, 1);
      waitPulse(1, 20, e); checkEq("ch1 one-shot latency", e, 15);
      seen = 0;
      for (int i = 0; i < 20; i++) begin
         stepCycle();
         if (bus.irq_pulse[1] === 1'b1) seen++;
      end
      checkEq("ch1 no repeat", seen, 0);
      bus.rd_ch = CH_W'(1);
      #1;
      checkEq("ch1 done count", 32'(bus.rd_count), 0);

      // Rewrite while the counter shows 2.
      applyStimulus(2, 7, 1, 0, 0);
      for (int i = 0; i < 5; i++) stepCycle();
      bus.rd_ch = CH_W'(2);
      #1;
      checkEq("ch2 count before rewrite", 32'(bus.rd_count), 2);
      applyStimulus(2, 5, 1, 0, 0);
      waitPulse(2, 12, e); checkEq("ch2 pulse after rewrite", e, 5);

      // Two channels expiring on the same edge.
      applyStimulus(0, 4, 1, 0, 0);
      applyStimulus(1, 3, 1, 0, 0);
      stepCycle();
      stepCycle();
      stepCycle();
      checkEq("simultaneous pulses", 32'(bus.irq_pulse[1:0]), 32'h3);

      // Zero reload with enable must stay idle.
      applyStimulus(3, 0, 1, 1, 0);
      waitPulse(3, 40, e); checkEq("ch3 zero reload never pulses", e, -1);

      // Reset mid-count on every channel.
      for (int c = 0; c < NUM_CH; c++) applyStimulus(c, 20, 1, 1, 0);
      for (int i = 0; i < 5; i++) stepCycle();
      reset = 1'b1;
      stepCycle();
      reset = 1'b0;
      checkEq("mid reset irq_pulse", 32'(bus.irq_pulse), 32'h0);
      checkEq("mid reset irq_pending", 32'(bus.irq_pending), 32'h0);
      checkEq("mid reset irq_any", 32'(bus.irq_any), 32'h0);
      seen = 0;
      for (int i = 0; i < 50; i++) begin
         stepCycle();
         if (bus.irq_pulse !== '0) seen++;
      end
      checkEq("no pulse after reset", seen, 0);

      // Random traffic with a fresh prescaler setting per round.
      for (int round = 0; round < 3; round++) begin
         reset = 1'b1;
         bus.presc_div = PRESC_W'($urandom_range(0, 3));
         stepCycle();
         reset = 1'b0;
         for (int i = 0; i < 250; i++) begin
            if ($urandom_range(0, 5) == 0) begin
               bus.cfg_we         = 1'b1;
               bus.cfg_ch         = CH_W'($urandom_range(0, NUM_CH - 1));
               bus.cfg_reload     = COUNT_W'($urandom_range(0, 9));
               bus.cfg_enable     = ($urandom_range(0, 7) != 0);
               bus.cfg_repeating  = 1'($urandom_range(0, 1));
               bus.cfg_divider_on = 1'($urandom_range(0, 1));
            end
            if ($urandom_range(0, 7) == 0) bus.irq_clear = NUM_CH'($urandom_range(0, 15));
            stepCycle();
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/multipit.md
MULTIPIT -- requirements
Module: multipit

Interface
REQ-001 Parameter NUM_CH, default 4: number of independent timer channels (1..8).
REQ-002 Parameter COUNT_W, default 16: width of each channel's down-counter and reload value.
REQ-003 Parameter PRESC_W, default 8: width of the shared prescaler.
REQ-004 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 cfg_we  input  1  one-cycle configuration write strobe.
REQ-007 cfg_ch  input  $clog2(NUM_CH)  target channel of the write; out-of-range values SHALL be ignored.
REQ-008 cfg_reload  input  COUNT_W  period in steps.
REQ-009 cfg_enable, cfg_repeating, cfg_divider_on  input  1 each  per-channel mode bits.
REQ-010 presc_div  input  PRESC_W  shared prescaler terminal value.
REQ-011 irq_clear  input  NUM_CH  per-channel pending-clear pulses.
REQ-012 rd_ch  input  $clog2(NUM_CH)  channel selected for rd_count.
REQ-013 rd_count  output  COUNT_W  current counter of channel rd_ch, combinational mux.
REQ-014 irq_pulse  output  NUM_CH  one-cycle expiry pulse per channel, registered.
REQ-015 irq_pending  output  NUM_CH  sticky expiry flag per channel, registered.
REQ-016 irq_any  output  1  OR of irq_pending.

Function
REQ-017 Prescaler SHALL count 0..presc_div and then wrap to 0; tick SHALL be high in the cycle its value equals presc_div; presc_div=0 SHALL tick every cycle.
REQ-018 Channel step SHALL be tick when divider_on=1, otherwise every cycle.
REQ-019 Channel states: IDLE, RUN, DONE.
REQ-020 Write with enable=1 and reload>0 SHALL load counter=reload, latch mode bits, enter RUN, overriding any count in progress.
REQ-021 Write with enable=0 or reload=0 SHALL enter IDLE with counter=0; irq_pending SHALL be unchanged.
REQ-022 In RUN, each step SHALL decrement the counter; a step at counter=1 is expiry.
REQ-023 On expiry, irq_pulse SHALL assert for exactly the next cycle and irq_pending SHALL set.
REQ-024 On expiry with repeating=1, counter SHALL reload to the latched reload value with no lost step; with repeating=0, channel SHALL enter DONE with counter=0.
REQ-025 Divider off, reload N: first irq_pulse SHALL be high exactly N cycles after the cfg_we cycle, then every N cycles.
REQ-026 DONE SHALL hold until the next write to that channel.
REQ-027 irq_clear and expiry in the same cycle: set SHALL win, pending remains 1.
REQ-028 Write and expiry for the same channel in the same cycle: the write SHALL win; no pulse.
REQ-029 Channels SHALL be fully independent; simultaneous expiries SHALL all be reported.

Reset
REQ-030 reset SHALL force: prescaler 0, all channels IDLE, counters 0, latched modes 0, irq_pulse 0, irq_pending 0, irq_any 0.
REQ-031 reset asserted mid-count SHALL abort all channels; no pulse SHALL follow.

Structure
REQ-032 Package multipit_pkg SHALL hold the channel-state enum (IDLE/RUN/DONE) and default parameter constants.
REQ-033 Sub-module multipit_channel (one channel: counter, state, pulse, pending) SHALL be instantiated NUM_CH times; prescaler and read mux stay in the top.

Verification
REQ-034 Ch0 reload=10, repeating, divider off -> irq_pulse[0] at cycles 10, 20, 30 after write; irq_pending[0] set, irq_any=1.
REQ-035 Ch1 reload=3, one-shot, divider on, presc_div=4 -> single pulse 15 cycles after write; state DONE, rd_count=0 thereafter.
REQ-036 irq_clear[0] in the same cycle as a ch0 expiry -> irq_pending[0] stays 1; clear alone one cycle later -> 0.
REQ-037 Rewrite ch2 reload=5 while counter=2 -> no pulse at old expiry; next pulse 5 cycles after the rewrite.
REQ-038 reset mid-count on all four channels -> all outputs 0 the next cycle and no pulses until reconfigured.
REQ-039 Write cfg_reload=0, enable=1 -> channel IDLE, never pulses.
